osc_freq_monitor: RTL

- Downstream consumer of the on-chip oscillator block.
- Runs on the fabric-routed 25/50 MHz RC oscillator clock (the O2F output after its global buffer).
- Measures a slower, asynchronous monitored clock by counting fabric-clock cycles across a fixed number of its rising edges, e.g. the 1 MHz RC oscillator or crystal oscillator O2F output.
- Flags out-of-window or stopped oscillators to system fault logic.

---
 rtl/osc_freq_monitor.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/osc_freq_monitor.sv
// -----------------------------------------------------------------------------
// osc_freq_monitor
//
// Measures a slow, asynchronous monitored clock (e.g. the 1 MHz RC or crystal
// oscillator output) by counting fabric-clock cycles across EDGE_COUNT of its
// rising edges. The count is then checked against [MIN_CYCLES, MAX_CYCLES].
// A stopped or out-of-window oscillator raises a sticky fault for the system
// fault logic.
//
// The monitored clock must stay below clk_i/4 for the measurement to be valid.
//
// Optional feature macro: OSC_FREQ_MONITOR_AUTORUN_EN
//   When it is defined, the first start_i begins continuous measurement.
//   DONE loops straight back to ALIGN, and only reset_i stops the monitor.
//
// Ports:
//   clk_i         fabric clock (50 MHz RC oscillator via global buffer)
//   reset_i       synchronous, active-high reset
//   mon_clk_i     monitored clock, asynchronous to clk_i
//   start_i       single-cycle request to begin one measurement
//   clr_fault_i   clears the sticky freq_fault_o
//   busy_o        high while a measurement is in progress
//   meas_valid_o  one-cycle pulse when a result is published
//   meas_count_o  last measured cycle count, saturated at MAX_CYCLES+1
//   freq_ok_o     last result was within [MIN_CYCLES, MAX_CYCLES]
//   freq_fault_o  sticky fault flag
// -----------------------------------------------------------------------------
module osc_freq_monitor #(
  parameter int EDGE_COUNT = 16,
  parameter int CNT_W      = 16,
  parameter int MIN_CYCLES = 784,
  parameter int MAX_CYCLES = 816
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             mon_clk_i,
  input  logic             start_i,
  input  logic             clr_fault_i,
  output logic             busy_o,
  output logic             meas_valid_o,
  output logic [CNT_W-1:0] meas_count_o,
  output logic             freq_ok_o,
  output logic             freq_fault_o
);

  localparam int                EDGE_W    = $clog2(EDGE_COUNT + 1);
  localparam logic [CNT_W-1:0]  MIN_C     = CNT_W'(MIN_CYCLES);
  localparam logic [CNT_W-1:0]  MAX_C     = CNT_W'(MAX_CYCLES);
  localparam logic [CNT_W-1:0]  SAT_C     = CNT_W'(MAX_CYCLES + 1);
  localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(EDGE_COUNT - 1);

  // The saturated result MAX_CYCLES+1 must be representable in CNT_W bits.
  generate
    if ((longint'(MAX_CYCLES) + 1) >= (longint'(1) << CNT_W)) begin : g_bad_width
      $error("osc_freq_monitor: MAX_CYCLES+1 does not fit in CNT_W bits");
    end
    if (EDGE_COUNT < 1) begin : g_bad_edges
      $error("osc_freq_monitor: EDGE_COUNT must be at least 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ALIGN,
    ST_MEASURE,
    ST_DONE
  } state_e;

  state_e              state_q;
  logic                sync1_q, sync2_q, hist_q;
  logic [CNT_W-1:0]    cyc_q;
  logic [EDGE_W-1:0]   edge_q;
  logic                busy_q, meas_valid_q, freq_ok_q, freq_fault_q;
  logic [CNT_W-1:0]    meas_count_q;

  logic                mon_rise;
  logic                finish_d;
  logic [CNT_W-1:0]    result_d;
  logic                result_ok_d;
  logic                fault_set;

  // Decide this cycle whether the measurement ends, and with which result.
  // The cycle counter never passes MAX_C. The window closes on the cycle it
  // would exceed MAX_C, so the result is clamped to SAT_C and never wraps.
  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    mon_rise = sync2_q & ~hist_q;
    finish_d = 1'b0;
    result_d = SAT_C;
    unique case (state_q)
      ST_ALIGN: begin
        if (!mon_rise && (cyc_q == MAX_C)) finish_d = 1'b1;
      end
      ST_MEASURE: begin
        if (mon_rise && (edge_q == LAST_EDGE)) begin
          finish_d = 1'b1;
          result_d = cyc_q + 1'b1;
        end else if (cyc_q == MAX_C) begin
          finish_d = 1'b1;
        end
      end
      default: ;
    endcase
    result_ok_d = (result_d >= MIN_C) && (result_d <= MAX_C);
    // A bad result counts as a fault on the edge into DONE and during DONE
    // itself. A coincident clr_fault_i therefore cannot cancel it.
    fault_set = (finish_d && !result_ok_d) || ((state_q == ST_DONE) && !freq_ok_q);
  end

  // NOTE: reset is synchronous and covers every flop, including the synchronizer.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= ST_IDLE;
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      hist_q       <= 1'b0;
      cyc_q        <= '0;
      edge_q       <= '0;
      busy_q       <= 1'b0;
      meas_valid_q <= 1'b0;
      meas_count_q <= '0;
      freq_ok_q    <= 1'b0;
      freq_fault_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only.
      // sync1_q is the only flop that may go metastable. hist_q delays
      // sync2_q by one cycle for rising-edge detection.
      sync1_q      <= mon_clk_i;
      sync2_q      <= sync1_q;
      hist_q       <= sync2_q;
      meas_valid_q <= 1'b0;

      if (fault_set)        freq_fault_q <= 1'b1;
      else if (clr_fault_i) freq_fault_q <= 1'b0;

      if (finish_d) begin
        // Publish on the edge into DONE, so results are visible during DONE.
        state_q      <= ST_DONE;
        busy_q       <= 1'b0;
        meas_valid_q <= 1'b1;
        meas_count_q <= result_d;
        freq_ok_q    <= result_ok_d;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            if (start_i) begin
              state_q <= ST_ALIGN;
              cyc_q   <= '0;
              busy_q  <= 1'b1;
            end
          end
          ST_ALIGN: begin
            if (mon_rise) begin
              state_q <= ST_MEASURE;
              cyc_q   <= '0;
              edge_q  <= '0;
            end else begin
              cyc_q <= cyc_q + 1'b1;
            end
          end
          ST_MEASURE: begin
            cyc_q <= cyc_q + 1'b1;
            if (mon_rise) edge_q <= edge_q + 1'b1;
          end
          ST_DONE: begin
`ifdef OSC_FREQ_MONITOR_AUTORUN_EN
            state_q <= ST_ALIGN;
            cyc_q   <= '0;
            busy_q  <= 1'b1;
`else
            state_q <= ST_IDLE;
`endif
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign busy_o       = busy_q;
  assign meas_valid_o = meas_valid_q;
  assign meas_count_o = meas_count_q;
  assign freq_ok_o    = freq_ok_q;
  assign freq_fault_o = freq_fault_q;

endmodule
